id_operand_scoreboard: RTL and testbench
========================================

Name: id_operand_scoreboard

Overview:
Parametrised operand-supply unit for the ID stage. It selects each source operand from the regfile or one of NUM_FWD forwarding stages, nearest stage first. A per-register countdown scoreboard tracks long-latency writes (loads, multiply/divide) and raises a stall request until the result has reached the regfile. It sits between the instruction decoder and the ID/EX pipeline register, and its stall request feeds the pipeline control block.

Parameters:
DATA_W, 32, operand/register width
ADDR_W, 5, register address width (2**ADDR_W registers)
NUM_PORTS, 2, operand read ports
NUM_FWD, 2, forwarding sources; index 0 = EX (nearest), higher = later stages
MAX_LAT, 7, largest legal issue latency in cycles
LAT_W, 3, counter width, ceil(log2(MAX_LAT+1))

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
id_valid_i  in  1  valid instruction in ID
rd_en_i  in  NUM_PORTS  per-port read enable
rd_addr_i  in  NUM_PORTS*ADDR_W  per-port register address
rf_data_i  in  NUM_PORTS*DATA_W  regfile read data
fwd_we_i  in  NUM_FWD  stage write enable
fwd_addr_i  in  NUM_FWD*ADDR_W  stage destination address
fwd_data_i  in  NUM_FWD*DATA_W  stage result
issue_i  in  1  ID issues a long-latency write this cycle
issue_waddr_i  in  ADDR_W  its destination register
issue_lat_i  in  LAT_W  cycles until the result is in the regfile
flush_i  in  1  cancel the ID instruction this cycle
op_data_o  out  NUM_PORTS*DATA_W  selected operands
stall_req_o  out  1  hold IF/ID, insert bubble
busy_o  out  1  any scoreboard entry nonzero

Behaviour:
- Reset (asynchronous, any time, including with ops in flight): all counters = 0. Outputs follow within the same cycle: stall_req_o = 0, busy_o = 0, op_data_o = 0.
- Operand select (combinational), per port k:
  - rd_en low -> 0.
  - addr == 0 -> 0, even if a stage writes reg 0 or rf_data is nonzero.
  - Otherwise the lowest-index fwd j with fwd_we[j] and fwd_addr[j] == addr supplies the operand. The address is compared, never the data.
  - No stage matches -> rf_data[k].
- Scoreboard: one LAT_W counter per register 1..2**ADDR_W-1. Reg 0 has no counter.
  - busy[r] = cnt[r] != 0.
  - Each clock, every nonzero counter decrements by 1.
- Accept: accept = issue_i & id_valid_i & ~flush_i & ~stall_req_o & issue_waddr_i != 0 & issue_lat_i != 0.
  - On accept, cnt[waddr] <= issue_lat_i. This overrides the decrement; the register is necessarily not busy at that point.
  - issue_lat_i == 0 or issue_lat_i > MAX_LAT: the issue is ignored and no entry is created. A lat > MAX_LAT is flagged by an assertion.
- stall_req_o (combinational from registered counters plus inputs) = id_valid_i & ~flush_i & (RAW | WAW).
  - RAW: any port k with rd_en, addr != 0 and busy[addr].
  - WAW: issue_i with busy[issue_waddr_i].
- The instruction being issued may read its own destination in the same cycle; this does not cause a stall.
- Latency: with issue accepted at edge t, a dependent read stalls for exactly issue_lat_i cycles. It proceeds in the cycle the counter reads 0; the regfile's internal write bypass supplies the data in that cycle.
- flush_i: suppresses that cycle's accept and stall. Counters for ops already in flight keep counting; they are never cancelled.
- busy_o = OR of all busy bits.

Optional Feature:
SB_PERF_CNT_EN
- Defined: adds output stall_cnt_o (32 bits), reset to 0. It increments each cycle stall_req_o is 1 and saturates at 0xFFFF_FFFF.
- Undefined: the port and the counter are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package holds:
  - default DATA_W and ADDR_W
  - zero-word and NOP register address constants
  - RstEnable / WriteEnable / ReadEnable levels
  - a LAT_W helper function
- One sub-module, id_fwd_mux: one instance per port, implementing the priority forwarding select for a single operand. The scoreboard stays in the top level.

Test Plan:
1. Priority: fwd0 {we=1, addr=1, data=0x22}, fwd1 {we=1, addr=1, data=0x11}, port0 reads reg 1 -> 0x22. Drop fwd0 -> 0x11. Drop both, rf_data=0x33 -> 0x33.
2. Reg 0: fwd0 {we=1, addr=0, data=0xFF}, rf_data=0x5, read reg 0 -> op_data 0, no stall. Read with rd_en=0 -> 0.
3. Load-use: accept issue waddr=3, lat=3 at edge t, then read reg 3 -> stall_req_o high for cycles t..t+2, low at t+3, busy_o low at t+3.
4. WAW: issue waddr=5, lat=4 accepted, then a new issue to reg 5 -> stall for 4 cycles, accepted the next cycle, counter reloaded to the new latency.
5. Reset mid-op: two entries pending (lat 7), assert rst asynchronously mid-cycle -> stall_req_o = 0 and busy_o = 0 before the next edge; reading those registers after release does not stall.
6. SB_PERF_CNT_EN: run scenario 3 twice -> stall_cnt_o = 6. flush_i held during a RAW -> no stall and no count.

Source files
------------

// File: rtl/id_operand_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// id_operand_scoreboard_pkg
// Shared constants and helpers for the ID-stage operand supply unit.
//   DEFAULT_DATA_W / DEFAULT_ADDR_W : default operand and register-address widths
//   ZERO_WORD                       : value returned for disabled / reg-0 reads
//   NOP_REG_ADDR                    : hard-wired zero register address
//   RST_ENABLE / WRITE_ENABLE /
//   READ_ENABLE                     : active levels of reset, stage write enable
//                                     and port read enable
//   lat_w_f()                       : counter width able to hold 0..max_lat
// -----------------------------------------------------------------------------
package id_operand_scoreboard_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;

    localparam logic [DEFAULT_DATA_W-1:0] ZERO_WORD    = '0;
    localparam logic [DEFAULT_ADDR_W-1:0] NOP_REG_ADDR = '0;

    localparam logic RST_ENABLE   = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic READ_ENABLE  = 1'b1;

    // Smallest width w with 2**w > max_lat, i.e. ceil(log2(max_lat+1)), min 1.
    function automatic int lat_w_f(input int max_lat);
        int w;
        w = 1;
        while ((1 << w) <= max_lat) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// -----------------------------------------------------------------------------
// id_fwd_mux
// Priority forwarding select for one source operand.
//   rd_en_i     : port read enable
//   rd_addr_i   : register being read
//   rf_data_i   : regfile read data for this port
//   fwd_we_i    : per-stage write enable (index 0 = EX, nearest)
//   fwd_addr_i  : per-stage destination address, flattened
//   fwd_data_i  : per-stage result, flattened
//   op_data_o   : selected operand
// The lowest-index stage whose address matches wins; only the address is
// compared. Register 0 and disabled reads always yield zero.
// -----------------------------------------------------------------------------
module id_fwd_mux
    import id_operand_scoreboard_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int NUM_FWD = 2
) (
    input  logic                        rd_en_i,
    input  logic [ADDR_W-1:0]           rd_addr_i,
    input  logic [DATA_W-1:0]           rf_data_i,
    input  logic [NUM_FWD-1:0]          fwd_we_i,
    input  logic [NUM_FWD*ADDR_W-1:0]   fwd_addr_i,
    input  logic [NUM_FWD*DATA_W-1:0]   fwd_data_i,
    output logic [DATA_W-1:0]           op_data_o
);

    always_comb begin : sel
        logic hit;
        hit       = 1'b0;
        op_data_o = rf_data_i;
        for (int j = 0; j < NUM_FWD; j++) begin
            if (!hit && fwd_we_i[j] == WRITE_ENABLE &&
                fwd_addr_i[j*ADDR_W +: ADDR_W] == rd_addr_i) begin
                op_data_o = fwd_data_i[j*DATA_W +: DATA_W];
                hit       = 1'b1;
            end
        end
        // A stage "writing" reg 0 must never leak through.
        if (rd_en_i != READ_ENABLE || rd_addr_i == ADDR_W'(NOP_REG_ADDR)) begin
            op_data_o = DATA_W'(ZERO_WORD);
        end
    end

endmodule

// File: rtl/id_operand_scoreboard.sv
// -----------------------------------------------------------------------------
// id_operand_scoreboard
// ID-stage operand supply: per-port forwarding select plus a per-register
// countdown scoreboard for long-latency writes.
//   clk, rst        : clock, asynchronous active-high reset
//   id_valid_i      : valid instruction in ID
//   rd_en_i/addr_i  : per-port read enable / register address
//   rf_data_i       : per-port regfile read data
//   fwd_we/addr/data: per-stage forwarding sources (index 0 nearest)
//   issue_i, issue_waddr_i, issue_lat_i : long-latency write being issued
//   flush_i         : cancel the ID instruction this cycle
//   op_data_o       : selected operands
//   stall_req_o     : hold IF/ID and insert a bubble
//   busy_o          : any scoreboard entry pending
//   stall_cnt_o     : stall cycle counter, present only with SB_PERF_CNT_EN
//
// Handshake: the ID instruction is "valid" when id_valid_i is high and is
// consumed ("ready") in any cycle where stall_req_o is low; flush_i drops it
// without consuming or stalling. An issue is only recorded when consumed.
//
// Counter timing: an issue accepted at edge t loads cnt = lat; a dependent
// reader sees cnt = lat..1 (stalls lat cycles) and proceeds when cnt = 0,
// when the regfile's own write bypass supplies the value.
// -----------------------------------------------------------------------------
module id_operand_scoreboard
    import id_operand_scoreboard_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int NUM_PORTS = 2,
    parameter int NUM_FWD   = 2,
    parameter int MAX_LAT   = 7,
    parameter int LAT_W     = lat_w_f(MAX_LAT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid_i,
    input  logic [NUM_PORTS-1:0]          rd_en_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]   rd_addr_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   rf_data_i,
    input  logic [NUM_FWD-1:0]            fwd_we_i,
    input  logic [NUM_FWD*ADDR_W-1:0]     fwd_addr_i,
    input  logic [NUM_FWD*DATA_W-1:0]     fwd_data_i,
    input  logic                          issue_i,
    input  logic [ADDR_W-1:0]             issue_waddr_i,
    input  logic [LAT_W-1:0]              issue_lat_i,
    input  logic                          flush_i,
    output logic [NUM_PORTS*DATA_W-1:0]   op_data_o,
    output logic                          stall_req_o,
    output logic                          busy_o
`ifdef SB_PERF_CNT_EN
    ,
    output logic [31:0]                   stall_cnt_o
`endif
);

    localparam int NREGS = 1 << ADDR_W;

    logic [NREGS-1:0]             busy;
    logic [NUM_PORTS*DATA_W-1:0]  mux_data;
    logic                         raw;
    logic                         waw;
    logic                         stall;
    logic                         accept;
    logic                         lat_legal;
    logic [31:0]                  lat_ext;

    // ---------------- operand select ----------------
    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        id_fwd_mux #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .NUM_FWD (NUM_FWD)
        ) u_fwd_mux (
            .rd_en_i    (rd_en_i[k]),
            .rd_addr_i  (rd_addr_i[k*ADDR_W +: ADDR_W]),
            .rf_data_i  (rf_data_i[k*DATA_W +: DATA_W]),
            .fwd_we_i   (fwd_we_i),
            .fwd_addr_i (fwd_addr_i),
            .fwd_data_i (fwd_data_i),
            .op_data_o  (mux_data[k*DATA_W +: DATA_W])
        );
    end

    // Operands are forced to zero while reset is held so downstream logic sees
    // a clean value in the same cycle reset is asserted.
    assign op_data_o = (rst == RST_ENABLE) ? '0 : mux_data;

    // ---------------- hazard detection ----------------
    always_comb begin
        raw = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (rd_en_i[k] == READ_ENABLE &&
                rd_addr_i[k*ADDR_W +: ADDR_W] != ADDR_W'(NOP_REG_ADDR) &&
                busy[rd_addr_i[k*ADDR_W +: ADDR_W]]) begin
                raw = 1'b1;
            end
        end
    end

    assign waw   = issue_i & busy[issue_waddr_i];
    assign stall = id_valid_i & ~flush_i & (raw | waw);

    // Widened so the upper-bound check stays meaningful for any LAT_W/MAX_LAT.
    assign lat_ext   = 32'(issue_lat_i);
    assign lat_legal = (issue_lat_i != '0) && (lat_ext <= 32'(MAX_LAT));

    assign accept = issue_i & id_valid_i & ~flush_i & ~stall &
                    (issue_waddr_i != ADDR_W'(NOP_REG_ADDR)) & lat_legal;

    // ---------------- countdown scoreboard ----------------
    assign busy[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
        logic [LAT_W-1:0] cnt_q;
        logic [LAT_W-1:0] cnt_d;

        // A reload only happens when the entry is idle (WAW stalls otherwise),
        // so it never collides with a live countdown.
        always_comb begin
            cnt_d = cnt_q;
            if (accept && issue_waddr_i == ADDR_W'(r)) begin
                cnt_d = issue_lat_i;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - LAT_W'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign busy[r] = (cnt_q != '0);
    end

    assign stall_req_o = stall;
    assign busy_o      = |busy;

    // An over-range latency is dropped by lat_legal; flag it for the designer.
    a_lat_range : assert property (@(posedge clk) disable iff (rst)
        !(issue_i && id_valid_i && (lat_ext > 32'(MAX_LAT))));

`ifdef SB_PERF_CNT_EN
    // ---------------- stall performance counter ----------------
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_operand_scoreboard.sv
`timescale 1ns/1ps
// Testbench for id_operand_scoreboard. Inputs are applied 1ns after each
// rising edge; the reference model pushes the expected outputs for that cycle
// into exp_q and the monitor pops and compares on the falling edge.
// The reference model tracks, per register, the first cycle in which its
// pending result is available (ready_cyc) rather than a countdown.
module tb_id_operand_scoreboard;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int NUM_PORTS = 2;
  localparam int NUM_FWD   = 2;
  localparam int MAX_LAT   = 7;
  localparam int LAT_W     = 3;
  localparam int NREGS     = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                        id_valid_i;
  logic [NUM_PORTS-1:0]        rd_en_i;
  logic [NUM_PORTS*ADDR_W-1:0] rd_addr_i;
  logic [NUM_PORTS*DATA_W-1:0] rf_data_i;
  logic [NUM_FWD-1:0]          fwd_we_i;
  logic [NUM_FWD*ADDR_W-1:0]   fwd_addr_i;
  logic [NUM_FWD*DATA_W-1:0]   fwd_data_i;
  logic                        issue_i;
  logic [ADDR_W-1:0]           issue_waddr_i;
  logic [LAT_W-1:0]            issue_lat_i;
  logic                        flush_i;
  logic [NUM_PORTS*DATA_W-1:0] op_data_o;
  logic                        stall_req_o;
  logic                        busy_o;
`ifdef SB_PERF_CNT_EN
  logic [31:0]                 stall_cnt_o;
`endif

  id_operand_scoreboard #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_PORTS(NUM_PORTS),
    .NUM_FWD(NUM_FWD), .MAX_LAT(MAX_LAT), .LAT_W(LAT_W)
  ) dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid_i),
    .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rf_data_i(rf_data_i),
    .fwd_we_i(fwd_we_i), .fwd_addr_i(fwd_addr_i), .fwd_data_i(fwd_data_i),
    .issue_i(issue_i), .issue_waddr_i(issue_waddr_i), .issue_lat_i(issue_lat_i),
    .flush_i(flush_i), .op_data_o(op_data_o), .stall_req_o(stall_req_o),
    .busy_o(busy_o)
`ifdef SB_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [NUM_PORTS*DATA_W-1:0] op;
    logic                        stall;
    logic                        busy;
    logic [31:0]                 scnt;
    logic [31:0]                 cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          ready_cyc[NREGS];
  logic [31:0] perf_exp = '0;

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    id_valid_i = 1'b0; rd_en_i = '0; rd_addr_i = '0; rf_data_i = '0;
    fwd_we_i = '0; fwd_addr_i = '0; fwd_data_i = '0;
    issue_i = 1'b0; issue_waddr_i = '0; issue_lat_i = '0; flush_i = 1'b0;
  endtask

  task automatic begin_cycle();
    @(posedge clk);
    cyc++;
    #1;
    set_idle();
    rst = 1'b0;
  endtask

  task automatic set_rd(input int k, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] rf);
    rd_en_i[k] = 1'b1;
    rd_addr_i[k*ADDR_W +: ADDR_W] = a;
    rf_data_i[k*DATA_W +: DATA_W] = rf;
  endtask

  task automatic set_fwd(input int j, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    fwd_we_i[j] = 1'b1;
    fwd_addr_i[j*ADDR_W +: ADDR_W] = a;
    fwd_data_i[j*DATA_W +: DATA_W] = d;
  endtask

  task automatic set_issue(input logic [ADDR_W-1:0] a, input logic [LAT_W-1:0] l);
    issue_i = 1'b1; issue_waddr_i = a; issue_lat_i = l;
  endtask

  // ---------------- reference model ----------------
  function automatic logic reg_pending(input int r);
    return (r != 0) && (cyc < ready_cyc[r]);
  endfunction

  function automatic logic [DATA_W-1:0] model_op(input int k);
    logic [ADDR_W-1:0] a;
    a = rd_addr_i[k*ADDR_W +: ADDR_W];
    if (!rd_en_i[k] || a == 0) return '0;
    for (int j = 0; j < NUM_FWD; j++)
      if (fwd_we_i[j] && fwd_addr_i[j*ADDR_W +: ADDR_W] == a)
        return fwd_data_i[j*DATA_W +: DATA_W];
    return rf_data_i[k*DATA_W +: DATA_W];
  endfunction

  // Computes this cycle's expected outputs and advances the model.
  task automatic commit();
    exp_t e;
    logic raw, waw, stl, any;
    e = '0;
    e.cyc = 32'(cyc);
    if (rst) begin
      for (int r = 0; r < NREGS; r++) ready_cyc[r] = 0;
      perf_exp = '0;
      exp_q.push_back(e);
      return;
    end
    raw = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      e.op[k*DATA_W +: DATA_W] = model_op(k);
      if (rd_en_i[k] && reg_pending(int'(rd_addr_i[k*ADDR_W +: ADDR_W]))) raw = 1'b1;
    end
    waw = issue_i && reg_pending(int'(issue_waddr_i));
    stl = id_valid_i && !flush_i && (raw || waw);
    any = 1'b0;
    for (int r = 1; r < NREGS; r++) if (reg_pending(r)) any = 1'b1;
    e.stall = stl;
    e.busy  = any;
    e.scnt  = perf_exp;
    exp_q.push_back(e);
    if (stl && perf_exp != 32'hFFFF_FFFF) perf_exp = perf_exp + 1;
    // Result reaches the regfile lat cycles after the loading edge (cyc+1).
    if (issue_i && id_valid_i && !flush_i && !stl && issue_waddr_i != 0 && issue_lat_i != 0)
      ready_cyc[issue_waddr_i] = cyc + 1 + int'(issue_lat_i);
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp,
                     input logic [31:0] c);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("op0", op_data_o[DATA_W-1:0], e.op[DATA_W-1:0], e.cyc);
      chk("op1", op_data_o[2*DATA_W-1:DATA_W], e.op[2*DATA_W-1:DATA_W], e.cyc);
      chk("stall_req", 32'(stall_req_o), 32'(e.stall), e.cyc);
      chk("busy", 32'(busy_o), 32'(e.busy), e.cyc);
`ifdef SB_PERF_CNT_EN
      chk("stall_cnt", stall_cnt_o, e.scnt, e.cyc);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic load_use(input logic [ADDR_W-1:0] r);
    begin_cycle(); id_valid_i = 1'b1; set_issue(r, 3'd3); commit();
    for (int i = 0; i < 5; i++) begin
      begin_cycle(); id_valid_i = 1'b1; set_rd(0, r, 32'hA5A5_0000 + 32'(i)); commit();
    end
  endtask

  initial begin
    for (int r = 0; r < NREGS; r++) ready_cyc[r] = 0;
    set_idle();
    rst = 1'b1;

    // reset state, with live inputs that must not leak through
    begin_cycle(); rst = 1'b1; id_valid_i = 1'b1;
    set_rd(0, 5'd1, 32'h1234_5678); set_fwd(0, 5'd1, 32'h9); commit();
    begin_cycle(); rst = 1'b1; commit();

    // forwarding priority
    begin_cycle(); id_valid_i = 1'b1;
    set_rd(0, 5'd1, 32'h33); set_rd(1, 5'd2, 32'h44);
    set_fwd(0, 5'd1, 32'h22); set_fwd(1, 5'd1, 32'h11); commit();
    begin_cycle(); id_valid_i = 1'b1;
    set_rd(0, 5'd1, 32'h33); set_rd(1, 5'd2, 32'h44);
    set_fwd(0, 5'd2, 32'h66); set_fwd(1, 5'd1, 32'h11); commit();
    begin_cycle(); id_valid_i = 1'b1;
    set_rd(0, 5'd1, 32'h33); set_rd(1, 5'd2, 32'h44); commit();

    // register 0 and disabled reads
    begin_cycle(); id_valid_i = 1'b1;
    set_rd(0, 5'd0, 32'h5); set_fwd(0, 5'd0, 32'hFF); commit();
    begin_cycle(); id_valid_i = 1'b1;
    rd_addr_i[ADDR_W-1:0] = 5'd1; rf_data_i[DATA_W-1:0] = 32'h5; commit();

    // load-use twice (stall count accumulates)
    load_use(5'd3);
    load_use(5'd3);

    // flush during a RAW hazard: no stall, no count
    begin_cycle(); id_valid_i = 1'b1; set_issue(5'd9, 3'd3); commit();
    begin_cycle(); id_valid_i = 1'b1; flush_i = 1'b1; set_rd(0, 5'd9, 32'h9); commit();
    begin_cycle(); id_valid_i = 1'b1; flush_i = 1'b1; set_rd(1, 5'd9, 32'h9); commit();
    for (int i = 0; i < 3; i++) begin begin_cycle(); commit(); end

    // WAW: reissue to reg 5 waits until the first write lands
    begin_cycle(); id_valid_i = 1'b1; set_issue(5'd5, 3'd4); commit();
    for (int i = 0; i < 5; i++) begin
      begin_cycle(); id_valid_i = 1'b1; set_issue(5'd5, 3'd2); commit();
    end
    for (int i = 0; i < 3; i++) begin
      begin_cycle(); id_valid_i = 1'b1; set_rd(1, 5'd5, 32'h55); commit();
    end

    // own-destination read in the issuing cycle does not stall
    begin_cycle(); id_valid_i = 1'b1; set_issue(5'd4, 3'd2); set_rd(0, 5'd4, 32'h4); commit();

    // asynchronous reset with two ops in flight
    begin_cycle(); id_valid_i = 1'b1; set_issue(5'd6, 3'd7); commit();
    begin_cycle(); id_valid_i = 1'b1; set_issue(5'd7, 3'd7); commit();
    begin_cycle(); id_valid_i = 1'b1; set_rd(0, 5'd6, 32'h6); commit();
    begin_cycle(); rst = 1'b1; id_valid_i = 1'b1;
    set_rd(0, 5'd6, 32'h66); set_rd(1, 5'd7, 32'h77); commit();
    begin_cycle(); id_valid_i = 1'b1;
    set_rd(0, 5'd6, 32'h66); set_rd(1, 5'd7, 32'h77); commit();

    // randomized traffic on a small register window to force hazards
    for (int i = 0; i < 400; i++) begin
      begin_cycle();
      rst = ($urandom_range(0, 149) == 0);
      id_valid_i = ($urandom_range(0, 9) != 0);
      for (int k = 0; k < NUM_PORTS; k++) begin
        if ($urandom_range(0, 4) != 0)
          set_rd(k, 5'($urandom_range(0, 7)), $urandom);
        else
          rf_data_i[k*DATA_W +: DATA_W] = $urandom;
      end
      for (int j = 0; j < NUM_FWD; j++)
        if ($urandom_range(0, 1) == 1) set_fwd(j, 5'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 9) < 3)
        set_issue(5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      flush_i = ($urandom_range(0, 9) == 0);
      commit();
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
